// File: rtl/gemm_pkg.sv
// Shared definitions for the gemm instruction front end: opcode, field
// positions inside a 128-bit VTA instruction, fetch FSM states and the
// GEMM field validity rule.
package gemm_pkg;

  localparam logic [2:0] OPC_GEMM = 3'd2;

  // Field positions inside the instruction word.
  localparam int unsigned OPC_LSB      = 0;
  localparam int unsigned OPC_MSB      = 2;
  localparam int unsigned UOP_BGN_LSB  = 8;
  localparam int unsigned UOP_BGN_MSB  = 20;
  localparam int unsigned UOP_END_LSB  = 21;
  localparam int unsigned UOP_END_MSB  = 34;
  localparam int unsigned ITER_OUT_LSB = 35;
  localparam int unsigned ITER_OUT_MSB = 48;
  localparam int unsigned ITER_IN_LSB  = 49;
  localparam int unsigned ITER_IN_MSB  = 62;
  localparam int unsigned DST_FAC_LSB  = 63;
  localparam int unsigned DST_FAC_MSB  = 73;
  localparam int unsigned SRC_FAC_LSB  = 74;
  localparam int unsigned SRC_FAC_MSB  = 84;
  localparam int unsigned WGT_FAC_LSB  = 85;
  localparam int unsigned WGT_FAC_MSB  = 94;

  // Highest bit the validity check looks at.
  localparam int unsigned DECODE_MSB   = ITER_IN_MSB;

  typedef enum logic [1:0] {
    StIdle,
    StCheck,
    StIssue,
    StWait
  } fetch_state_e;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [12:0] uop_bgn;
    logic [13:0] uop_end;
    logic [13:0] iter_out;
    logic [13:0] iter_in;
  } gemm_fields_t;

  // A GEMM insn is usable when it is a GEMM opcode, has a non-empty uop
  // range and both loop counts are non-zero.
  function automatic logic gemm_fields_ok(input gemm_fields_t f);
    logic range_ok;
    range_ok = f.uop_end > {1'b0, f.uop_bgn};
    return (f.opcode == OPC_GEMM) && range_ok && (f.iter_out != '0) && (f.iter_in != '0);
  endfunction

endpackage

// File: rtl/gemm_insn_fetch_if.sv
// Instruction handshake between the loader, the fetch unit and the gemm core.
// The fetch unit is the slave; the loader/gemm side is the master.
interface gemm_insn_fetch_if #(
  parameter int unsigned INS_WIDTH = 128
) ();

  logic [INS_WIDTH-1:0] insn_in;
  logic                 insn_in_valid;
  logic                 insn_in_ready;
  logic [INS_WIDTH-1:0] insn;
  logic                 gemm_start;
  logic                 gemm_done;

  modport master (
    output insn_in,
    output insn_in_valid,
    output gemm_done,
    input  insn_in_ready,
    input  insn,
    input  gemm_start
  );

  modport slave (
    input  insn_in,
    input  insn_in_valid,
    input  gemm_done,
    output insn_in_ready,
    output insn,
    output gemm_start
  );

endinterface

// File: rtl/insn_fifo.sv
// Small synchronous FIFO buffering instructions ahead of the fetch FSM.
// Pushes into a full FIFO and pops from an empty one are ignored.
module insn_fifo #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_en,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push, pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem_q[rd_ptr_q];

  // Storage needs no reset; only valid entries are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Pointers wrap at DEPTH-1; occupancy tracks push/pop, unchanged when both happen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

endmodule

// File: rtl/gemm_insn_fetch.sv
// Instruction fetch for the gemm core: buffers incoming insns, pops one at a
// time, validates its GEMM fields, pulses gemm_start for accepted insns and
// waits for gemm_done before moving on. Rejected insns are counted and skipped.
module gemm_insn_fetch
  import gemm_pkg::*;
#(
  parameter int unsigned INS_WIDTH  = 128,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  gemm_insn_fetch_if.slave     bus,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] issue_cnt,
  output logic [CNT_WIDTH-1:0] drop_cnt
);

  logic [INS_WIDTH-1:0] fifo_rd_data;
  logic                 fifo_full, fifo_empty, fifo_pop;

  fetch_state_e         state_q;
  logic [INS_WIDTH-1:0] insn_q;
  logic                 start_q;
  logic [CNT_WIDTH-1:0] issue_cnt_q, drop_cnt_q;

  gemm_fields_t         fields;
  logic                 insn_ok;

  insn_fifo #(
    .WIDTH (INS_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_data (bus.insn_in),
    .wr_en   (bus.insn_in_valid),
    .full    (fifo_full),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty)
  );

  // The head is consumed only when IDLE latches it into insn_q.
  assign fifo_pop = (state_q == StIdle) && !fifo_empty;

  // Decode the latched insn; stable from CHECK onwards.
  always_comb begin
    fields          = '0;
    fields.opcode   = insn_q[OPC_MSB:OPC_LSB];
    fields.uop_bgn  = insn_q[UOP_BGN_MSB:UOP_BGN_LSB];
    fields.uop_end  = insn_q[UOP_END_MSB:UOP_END_LSB];
    fields.iter_out = insn_q[ITER_OUT_MSB:ITER_OUT_LSB];
    fields.iter_in  = insn_q[ITER_IN_MSB:ITER_IN_LSB];
  end

  assign insn_ok = gemm_fields_ok(fields);

  // Fetch FSM with registered start pulse and saturating counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      insn_q      <= '0;
      start_q     <= 1'b0;
      issue_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            insn_q  <= fifo_rd_data;
            state_q <= StCheck;
          end
        end
        StCheck: begin
          if (insn_ok) begin
            start_q <= 1'b1;
            state_q <= StIssue;
          end else begin
            if (~&drop_cnt_q) begin
              drop_cnt_q <= drop_cnt_q + CNT_WIDTH'(1);
            end
            state_q <= StIdle;
          end
        end
        StIssue: begin
          // Done is not looked at here; WAIT samples it from the next cycle.
          start_q <= 1'b0;
          if (~&issue_cnt_q) begin
            issue_cnt_q <= issue_cnt_q + CNT_WIDTH'(1);
          end
          state_q <= StWait;
        end
        StWait: begin
          if (bus.gemm_done) begin
            state_q <= StIdle;
          end
        end
        default: begin
          start_q <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.insn_in_ready = !fifo_full;
  assign bus.insn          = insn_q;
  assign bus.gemm_start    = start_q;
  assign busy              = (state_q != StIdle) || !fifo_empty;
  assign issue_cnt         = issue_cnt_q;
  assign drop_cnt          = drop_cnt_q;

endmodule

// File: tb/tb_gemm_insn_fetch.sv
// Self-checking bench for gemm_insn_fetch: reset state, a decode table,
// hand-written timing sequences and a randomized run against a transaction
// model (queue of accepted insns in push order, expected counts).
module tb_gemm_insn_fetch;

  localparam int unsigned W   = 128;
  localparam int unsigned D   = 4;
  localparam int unsigned CW  = 4;
  localparam int unsigned SAT = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          busy;
  logic [CW-1:0] issue_cnt, drop_cnt;

  gemm_insn_fetch_if #(.INS_WIDTH(W)) bus ();

  gemm_insn_fetch #(
    .INS_WIDTH  (W),
    .FIFO_DEPTH (D),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .issue_cnt (issue_cnt),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int exp_issue = 0;
  int exp_drop = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] insn;
    int           cyc;
  } start_t;
  start_t started[$];

  // Record every start pulse mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (bus.gemm_start) started.push_back('{insn: bus.insn, cyc: cyc});
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic report_timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out, got no event expected one", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat(input int v);
    return (v > int'(SAT)) ? int'(SAT) : v;
  endfunction

  function automatic logic [W-1:0] mk(input logic [2:0] opc, input int bgn, input int en,
                                      input int io, input int ii);
    logic [W-1:0] r;
    r        = '0;
    r[2:0]   = opc;
    r[20:8]  = bgn[12:0];
    r[34:21] = en[13:0];
    r[48:35] = io[13:0];
    r[62:49] = ii[13:0];
    return r;
  endfunction

  // Reference acceptance rule, evaluated with plain integers.
  function automatic bit model_ok(input logic [W-1:0] x);
    int unsigned opc, bgn, en, io, ii;
    opc = x[2:0];
    bgn = x[20:8];
    en  = x[34:21];
    io  = x[48:35];
    ii  = x[62:49];
    return (opc == 2) && (en > bgn) && (io != 0) && (ii != 0);
  endfunction

  // Present x and hold it until the handshake completes (bounded).
  task automatic push(input logic [W-1:0] x);
    int n;
    n = 0;
    bus.insn_in       = x;
    bus.insn_in_valid = 1'b1;
    while (!bus.insn_in_ready && n < 300) begin
      step();
      n++;
    end
    if (!bus.insn_in_ready) report_timeout("push_ready");
    step();
    bus.insn_in_valid = 1'b0;
  endtask

  task automatic wait_start(input string name, input int budget, output bit ok);
    int n;
    n = 0;
    while (!bus.gemm_start && n < budget) begin
      step();
      n++;
    end
    ok = bus.gemm_start;
    if (!ok) report_timeout(name);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    if (busy) report_timeout(name);
  endtask

  task automatic pulse_done();
    bus.gemm_done = 1'b1;
    step();
    bus.gemm_done = 1'b0;
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    exp_issue = 0;
    exp_drop  = 0;
  endtask

  task automatic chk_counts(input string name);
    chk({name, "_issue_cnt"}, issue_cnt, sat(exp_issue));
    chk({name, "_drop_cnt"}, drop_cnt, sat(exp_drop));
  endtask

  typedef struct {
    logic [W-1:0] insn;
    bit           accept;
    string        name;
  } vec_t;

  vec_t         tab[11];
  logic [W-1:0] p[6];
  logic [W-1:0] rlist[30];
  logic [W-1:0] exp_q[$];

  initial begin
    bit ok;
    int base, s1, nd;
    logic [W-1:0] x, a, c;

    tab[0]  = '{mk(3'd0, 1, 2, 1, 1), 1'b0, "opc0"};
    tab[1]  = '{mk(3'd2, 5, 5, 1, 1), 1'b0, "end_eq_bgn"};
    tab[2]  = '{mk(3'd2, 3, 4, 1, 0), 1'b0, "iter_in0"};
    tab[3]  = '{mk(3'd2, 3, 4, 0, 1), 1'b0, "iter_out0"};
    tab[4]  = '{mk(3'd3, 1, 2, 1, 1), 1'b0, "opc3"};
    tab[5]  = '{mk(3'd2, 5, 4, 1, 1), 1'b0, "end_lt_bgn"};
    tab[6]  = '{mk(3'd2, 8191, 8192, 1, 1), 1'b1, "bgn_max_zext"};
    tab[7]  = '{mk(3'd2, 8191, 8191, 1, 1), 1'b0, "bgn_max_eq"};
    tab[8]  = '{mk(3'd2, 0, 16383, 16383, 16383), 1'b1, "fields_max"};
    tab[9]  = '{mk(3'd2, 1, 2, 1, 1), 1'b1, "upper_bits"};
    tab[9].insn[127:63] = {$urandom(), $urandom(), 1'b1};
    tab[10] = '{mk(3'd2, 2, 9, 3, 4), 1'b1, "mid_bits_set"};
    tab[10].insn[7:3] = 5'h1f;

    bus.insn_in       = '0;
    bus.insn_in_valid = 1'b0;
    bus.gemm_done     = 1'b0;

    // Reset state.
    #2;
    rst = 1'b0;
    step();
    step();
    chk("rst_ready", bus.insn_in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_start", bus.gemm_start, 1'b0);
    chk("rst_insn", bus.insn, '0);
    chk("rst_issue_cnt", issue_cnt, '0);
    chk("rst_drop_cnt", drop_cnt, '0);
    rst = 1'b1;
    step();

    // Single valid insn: start in cycle 3 only, done in cycle 6, idle in 7.
    x = mk(3'd2, 1, 2, 16, 1);
    push(x);                                   // now cycle 1
    chk("t1_busy_c1", busy, 1'b1);
    chk("t1_start_c1", bus.gemm_start, 1'b0);
    step();                                    // cycle 2
    chk("t1_start_c2", bus.gemm_start, 1'b0);
    step();                                    // cycle 3
    chk("t1_start_c3", bus.gemm_start, 1'b1);
    chk("t1_insn_c3", bus.insn, x);
    step();                                    // cycle 4
    chk("t1_start_c4", bus.gemm_start, 1'b0);
    step();
    step();                                    // cycle 6
    chk("t1_insn_c6", bus.insn, x);
    chk("t1_busy_c6", busy, 1'b1);
    pulse_done();                              // cycle 7
    exp_issue = 1;
    chk("t1_busy_c7", busy, 1'b0);
    chk_counts("t1");

    // Decode table: one insn at a time, start in cycle 3 exactly when accepted.
    for (int i = 0; i < 11; i++) begin
      push(tab[i].insn);                       // cycle 1
      step();                                  // cycle 2
      chk({tab[i].name, "_start_c2"}, bus.gemm_start, 1'b0);
      step();                                  // cycle 3
      chk({tab[i].name, "_start_c3"}, bus.gemm_start, tab[i].accept);
      if (tab[i].accept) begin
        chk({tab[i].name, "_insn"}, bus.insn, tab[i].insn);
        exp_issue++;
        step();
        pulse_done();
      end else begin
        exp_drop++;
      end
      chk({tab[i].name, "_idle"}, busy, 1'b0);
      chk_counts(tab[i].name);
    end

    // Done during the ISSUE cycle is ignored; WAIT still needs its own done.
    push(mk(3'd2, 4, 6, 2, 2));
    step();
    step();                                    // cycle 3, ISSUE
    bus.gemm_done = 1'b1;
    step();
    bus.gemm_done = 1'b0;
    step();
    chk("issue_done_still_wait", busy, 1'b1);
    pulse_done();
    exp_issue++;
    chk("issue_done_idle", busy, 1'b0);
    chk_counts("issue_done");

    // Mix: valid, opc=3, valid. The reject costs an IDLE+CHECK pair, so the
    // second start lands 5 cycles after the first done is sampled.
    base = started.size();
    a = mk(3'd2, 10, 20, 5, 5);
    c = mk(3'd2, 30, 31, 7, 8);
    push(a);
    push(mk(3'd3, 1, 2, 1, 1));
    push(c);
    wait_start("mix_start1", 20, ok);
    step();
    nd = cyc;
    pulse_done();
    wait_start("mix_start2", 20, ok);
    chk("mix_start_gap", cyc - nd, 5);
    chk("mix_insn2", bus.insn, c);
    step();
    pulse_done();
    wait_idle("mix_idle", 50);
    exp_issue += 2;
    exp_drop++;
    chk("mix_nstarts", started.size() - base, 2);
    chk_counts("mix");

    // Fill the buffer with no done: ready drops, nothing is lost, order kept.
    base = started.size();
    for (int i = 0; i < 6; i++) p[i] = mk(3'd2, i, i + 1, 1, 1 + i);
    for (int i = 0; i < 5; i++) push(p[i]);
    chk("fill_ready_low", bus.insn_in_ready, 1'b0);
    bus.insn_in       = p[5];
    bus.insn_in_valid = 1'b1;
    step();
    step();
    chk("fill_ready_still_low", bus.insn_in_ready, 1'b0);
    pulse_done();
    push(p[5]);
    for (int i = 0; i < 5; i++) begin
      wait_start("fill_start", 40, ok);
      if (!ok) break;
      step();
      pulse_done();
    end
    wait_idle("fill_idle", 50);
    exp_issue += 6;
    chk("fill_nstarts", started.size() - base, 6);
    for (int i = 0; i < 6; i++) begin
      if (base + i < started.size()) chk("fill_order", started[base + i].insn, p[i]);
    end
    chk_counts("fill");

    // gemm_done held high: one start per insn, WAIT lasts a single cycle.
    base = started.size();
    bus.gemm_done = 1'b1;
    push(mk(3'd2, 1, 3, 1, 1));
    push(mk(3'd2, 2, 3, 1, 1));
    wait_start("held_start1", 20, ok);
    s1 = cyc;
    step();
    wait_start("held_start2", 20, ok);
    chk("held_start_gap", cyc - s1, 4);
    wait_idle("held_idle", 20);
    bus.gemm_done = 1'b0;
    exp_issue += 2;
    chk("held_nstarts", started.size() - base, 2);
    chk_counts("held");

    // Reset in WAIT with two insns still buffered.
    push(mk(3'd2, 1, 2, 1, 1));
    push(mk(3'd2, 1, 2, 1, 2));
    push(mk(3'd2, 1, 2, 1, 3));
    wait_start("rstw_start", 20, ok);
    step();                                    // WAIT, two buffered
    chk("rstw_busy_before", busy, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("rstw_ready", bus.insn_in_ready, 1'b1);
    chk("rstw_busy", busy, 1'b0);
    chk("rstw_start_low", bus.gemm_start, 1'b0);
    chk("rstw_insn", bus.insn, '0);
    chk("rstw_issue_cnt", issue_cnt, '0);
    chk("rstw_drop_cnt", drop_cnt, '0);
    @(negedge clk);
    rst = 1'b1;
    base = started.size();
    repeat (8) step();
    chk("rstw_no_start", started.size() - base, 0);
    chk("rstw_empty", busy, 1'b0);
    exp_issue = 0;
    exp_drop  = 0;

    // 17 rejects saturate a 4-bit drop counter at 15.
    base = started.size();
    for (int i = 0; i < 17; i++) push(mk(3'd0, i, i + 1, 1, 1));
    wait_idle("sat_idle", 200);
    exp_drop = 17;
    chk("sat_drop_cnt", drop_cnt, 4'hf);
    chk("sat_no_start", started.size() - base, 0);

    // Randomized run against the transaction model.
    do_reset();
    started.delete();
    exp_q.delete();
    for (int i = 0; i < 30; i++) begin
      x = {$urandom(), $urandom(), $urandom(), $urandom()};
      x[2:0] = ($urandom_range(0, 9) < 7) ? 3'd2 : 3'($urandom_range(0, 7));
      x[20:8] = 13'($urandom_range(0, 40));
      x[34:21] = 14'($urandom_range(0, 40));
      if ($urandom_range(0, 9) == 0) x[48:35] = '0;
      if ($urandom_range(0, 9) == 0) x[62:49] = '0;
      rlist[i] = x;
      if (model_ok(x)) begin
        exp_q.push_back(x);
        exp_issue++;
      end else begin
        exp_drop++;
      end
    end
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 3)) step();
          push(rlist[i]);
        end
      end
      begin
        bit rok;
        for (int k = 0; k < exp_q.size(); k++) begin
          wait_start("rand_start", 400, rok);
          if (!rok) break;
          step();
          repeat ($urandom_range(0, 3)) step();
          pulse_done();
        end
      end
    join
    wait_idle("rand_idle", 400);
    chk("rand_nstarts", started.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < started.size()) chk("rand_order", started[i].insn, exp_q[i]);
    end
    chk_counts("rand");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
